// File: rtl/stepdown_seq_pkg.sv
// stepdown_seq_pkg: shared state encoding and widths for the stepdown gate sequencer
package stepdown_seq_pkg;
  localparam int STATE_W = 3;
  localparam int OCP_CNT_W = 4;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_DT_HS = 3'd1,
    ST_HS_ON = 3'd2,
    ST_DT_LS = 3'd3,
    ST_LS_ON = 3'd4,
    ST_FAULT = 3'd5
  } state_t;
endpackage

// File: rtl/stepdown_seq_timer.sv
// stepdown_seq_timer: loadable saturating down counter with zero flag
module stepdown_seq_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_val,
  output logic          o_zero
);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/stepdown_gate_sequencer.sv
// stepdown_gate_sequencer: turns the gated PWM request into non-overlapping
// high/low-side gate enables with dead time, min on/off, OCP blanking and fault latch
module stepdown_gate_sequencer
  import stepdown_seq_pkg::*;
#(
  parameter int CW        = 8,
  parameter int DT_CYC    = 4,
  parameter int MIN_ON    = 8,
  parameter int MIN_OFF   = 6,
  parameter int OCP_BLANK = 3,
  parameter int OCP_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CELV,
  input  logic       CELG,
  input  logic       SUB,
  input  logic       en,
  input  logic       pwm_req,
  input  logic       ocp,
  input  logic       zcd,
  output logic       hs_on,
  output logic       ls_on,
  output logic       fault,
  output logic [2:0] state
);
  localparam logic [CW-1:0] L_DT  = CW'(DT_CYC - 1);
  localparam logic [CW-1:0] L_ON  = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] L_OFF = CW'(MIN_OFF - 1);
  // the turn-on cycle itself counts as the first blanked cycle
  localparam logic [CW-1:0] L_BLANK = CW'(OCP_BLANK > 0 ? OCP_BLANK - 1 : 0);
  localparam logic [OCP_CNT_W-1:0] L_LIMIT = OCP_CNT_W'(OCP_LIMIT);

  state_t                 r_state, w_next;
  logic                   r_hs, r_ls, r_fault;
  logic [OCP_CNT_W-1:0]   r_ocp_cnt;
  logic                   w_cnt_load, w_blank_load, w_cnt_zero, w_blank_zero;
  logic                   w_ocp_inc, w_ocp_clr;
  logic [CW-1:0]          w_cnt_val;
  logic                   w_unused;

  assign w_unused = ^{CELV, CELG, SUB};

  stepdown_seq_timer #(.CW(CW)) u_cnt (
    .clk(clk), .rst(rst), .i_load(w_cnt_load), .i_val(w_cnt_val), .o_zero(w_cnt_zero)
  );

  stepdown_seq_timer #(.CW(CW)) u_blank (
    .clk(clk), .rst(rst), .i_load(w_blank_load), .i_val(L_BLANK), .o_zero(w_blank_zero)
  );

  always_comb begin
    w_next       = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_val    = '0;
    w_blank_load = 1'b0;
    w_ocp_inc    = 1'b0;
    w_ocp_clr    = 1'b0;
    if (!en) begin
      w_next     = ST_IDLE;
      w_cnt_load = 1'b1;
      w_cnt_val  = L_OFF;
      w_ocp_clr  = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: if (pwm_req && w_cnt_zero) begin
          w_next     = ST_DT_HS;
          w_cnt_load = 1'b1;
          w_cnt_val  = L_DT;
        end
        ST_DT_HS: if (w_cnt_zero) begin
          w_next       = ST_HS_ON;
          w_cnt_load   = 1'b1;
          w_cnt_val    = L_ON;
          w_blank_load = 1'b1;
        end
        ST_HS_ON: if (ocp && w_blank_zero) begin
          w_next     = ST_DT_LS;
          w_cnt_load = 1'b1;
          w_cnt_val  = L_DT;
          w_ocp_inc  = 1'b1;
        end else if (w_cnt_zero && !pwm_req) begin
          w_next     = ST_DT_LS;
          w_cnt_load = 1'b1;
          w_cnt_val  = L_DT;
          w_ocp_clr  = 1'b1;
        end
        ST_DT_LS: if (w_cnt_zero) begin
          w_next     = (r_ocp_cnt >= L_LIMIT) ? ST_FAULT : ST_LS_ON;
          w_cnt_load = 1'b1;
          w_cnt_val  = L_OFF;
        end
        // zcd leaves cnt running so IDLE still honours the remaining min-off
        ST_LS_ON: if (zcd) begin
          w_next = ST_IDLE;
        end else if (w_cnt_zero && pwm_req) begin
          w_next     = ST_DT_HS;
          w_cnt_load = 1'b1;
          w_cnt_val  = L_DT;
        end
        ST_FAULT: w_next = ST_FAULT;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hs      <= 1'b0;
      r_ls      <= 1'b0;
      r_fault   <= 1'b0;
      r_ocp_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_hs      <= (w_next == ST_HS_ON);
      r_ls      <= (w_next == ST_LS_ON);
      r_fault   <= (w_next == ST_FAULT);
      r_ocp_cnt <= w_ocp_clr ? '0 :
                   (w_ocp_inc && r_ocp_cnt != '1) ? r_ocp_cnt + 1'b1 : r_ocp_cnt;
    end
  end

  assign hs_on = r_hs;
  assign ls_on = r_ls;
  assign fault = r_fault;
  assign state = r_state;
endmodule

// File: tb/tb_stepdown_gate_sequencer.sv
// tb_stepdown_gate_sequencer: vector table, corner-case sequences and randomized
// run against a behavioural model of the gate sequencer
module tb_stepdown_gate_sequencer;
  localparam int DT_CYC = 4, MIN_ON = 8, MIN_OFF = 6, OCP_BLANK = 3, OCP_LIMIT = 4;

  logic clk = 0, rst = 0, en = 0, pwm_req = 0, ocp = 0, zcd = 0;
  logic hs_on, ls_on, fault;
  logic [2:0] state;
  int checks = 0, errors = 0;

  typedef struct {
    logic e, p, o, z;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[$];

  int m_st, m_wait, m_age, m_trips;

  always #5 clk = ~clk;

  stepdown_gate_sequencer #(
    .CW(8), .DT_CYC(DT_CYC), .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF),
    .OCP_BLANK(OCP_BLANK), .OCP_LIMIT(OCP_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .en(en), .pwm_req(pwm_req), .ocp(ocp), .zcd(zcd),
    .hs_on(hs_on), .ls_on(ls_on), .fault(fault), .state(state)
  );

  function automatic vec_t mk(logic e, logic p, logic o, logic z, int st, logic h, logic l, logic f);
    vec_t v;
    v.e = e; v.p = p; v.o = o; v.z = z;
    v.exp = {3'(st), h, l, f};
    return v;
  endfunction

  function automatic logic [5:0] obs();
    return {state, hs_on, ls_on, fault};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic p, input logic o, input logic z);
    en = e; pwm_req = p; ocp = o; zcd = z;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: tracks remaining wait, cycles spent with the high side on,
  // and the run of OCP-terminated periods.
  task automatic model_step(input logic e, input logic p, input logic o, input logic z);
    int nst;
    int nw;
    int nage;
    int ntr;
    nst = m_st;
    nw = (m_wait > 0) ? m_wait - 1 : 0;
    nage = m_age + 1;
    ntr = m_trips;
    if (!e) begin
      nst = 0; nw = MIN_OFF - 1; ntr = 0;
    end else if (m_st == 0) begin
      if (p && m_wait == 0) begin nst = 1; nw = DT_CYC - 1; end
    end else if (m_st == 1) begin
      if (m_wait == 0) begin nst = 2; nw = MIN_ON - 1; nage = 1; end
    end else if (m_st == 2) begin
      if (o && m_age >= OCP_BLANK) begin
        nst = 3; nw = DT_CYC - 1; ntr = (m_trips < 15) ? m_trips + 1 : 15;
      end else if (m_wait == 0 && !p) begin
        nst = 3; nw = DT_CYC - 1; ntr = 0;
      end
    end else if (m_st == 3) begin
      if (m_wait == 0) begin nst = (ntr >= OCP_LIMIT) ? 5 : 4; nw = MIN_OFF - 1; end
    end else if (m_st == 4) begin
      if (z) nst = 0;
      else if (m_wait == 0 && p) begin nst = 1; nw = DT_CYC - 1; end
    end
    m_st = nst; m_wait = nw; m_age = nage; m_trips = ntr;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n, run, runs, off_run, lvl;
    logic ls4, prev, re, rp, ro, rz;
    #1 rst = 1;
    #2 chk("reset_async", obs(), 6'd0);
    tick();
    chk("reset_hold", obs(), 6'd0);
    rst = 0;

    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0));
    for (int i = 2; i <= 4; i++)   tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 5; i <= 12; i++)  tbl.push_back(mk(1, 0, 0, 0, 2, 1, 0, 0));
    for (int i = 13; i <= 16; i++) tbl.push_back(mk(1, 0, 0, 0, 3, 0, 0, 0));
    for (int i = 17; i <= 18; i++) tbl.push_back(mk(1, 0, 0, 0, 4, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 20; i <= 22; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 23; i <= 26; i++) tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2, 1, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i].e, tbl[i].p, tbl[i].o, tbl[i].z);
      tick();
      chk($sformatf("vec%0d", i + 1), obs(), tbl[i].exp);
    end

    drive(1, 0, 0, 0);
    n = 1;
    for (int k = 0; k < 40 && hs_on; k++) begin
      tick();
      if (hs_on) n++;
    end
    chk("min_on_width", n, MIN_ON);

    drive(0, 0, 0, 0);
    tick();
    chk("en_low_idle", obs(), 6'd0);
    drive(1, 1, 1, 0);
    run = 0; runs = 0; ls4 = 0;
    for (int k = 0; k < 400 && !fault; k++) begin
      tick();
      if (hs_on) run++;
      else if (run > 0) begin
        chk("ocp_blank_width", run, OCP_BLANK);
        runs++;
        run = 0;
      end
      if (runs >= OCP_LIMIT && ls_on) ls4 = 1;
    end
    chk("ocp_periods", runs, OCP_LIMIT);
    chk("fault_state", obs(), {3'd5, 1'b0, 1'b0, 1'b1});
    chk("no_ls_at_limit", ls4, 0);
    repeat (5) tick();
    chk("fault_sticky", obs(), {3'd5, 1'b0, 1'b0, 1'b1});
    drive(0, 1, 1, 0);
    tick();
    chk("fault_clear", obs(), 6'd0);

    drive(1, 1, 0, 0);
    for (int k = 0; k < 60 && !hs_on; k++) tick();
    chk("reach_hs_on", hs_on, 1);
    @(negedge clk);
    rst = 1;
    #1 chk("async_rst_mid_hs", obs(), 6'd0);
    tick();
    rst = 0;

    m_st = 0; m_wait = 0; m_age = 0; m_trips = 0;
    off_run = 100; prev = 0; lvl = 0; rp = 0;
    for (int c = 0; c < 10000; c++) begin
      if (c % 256 == 0) lvl = $urandom_range(0, 3);
      re = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) == 0) rp = ~rp;
      ro = ($urandom_range(0, 3) < lvl);
      rz = ($urandom_range(0, 7) == 0);
      drive(re, rp, ro, rz);
      model_step(re, rp, ro, rz);
      tick();
      chk("rand_model", obs(), {3'(m_st), m_st == 2, m_st == 4, m_st == 5});
      chk("rand_overlap", hs_on & ls_on, 0);
      if (hs_on | ls_on) begin
        if (!prev) chk("rand_dead_gap", off_run >= DT_CYC, 1);
        off_run = 0;
        prev = 1;
      end else begin
        off_run++;
        prev = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
